// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: boot delay, redirect/predict/sequential PC
// selection, stall handling with a single latest-wins pending redirect, halt.
module pc_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              BOOT_WAIT = 2,
  parameter int              ALIGN     = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pc_enable,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_predict_taken,
  input  logic [XLEN-1:0] i_predict_pc,
  input  logic            i_halt,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_valid,
  output logic            o_redirect_pending
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Last BOOT cycle index; the transition to RUN happens on that edge.
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_WAIT - 1);

  // Mask that clears the low ALIGN bits of any loaded target.
  logic [XLEN-1:0] align_mask;
  for (genvar gi = 0; gi < XLEN; gi++) begin : g_align_mask
    assign align_mask[gi] = (gi >= ALIGN);
  end

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            valid_reg, valid_next;
  logic            pend_reg, pend_next;
  logic [XLEN-1:0] pend_pc_reg, pend_pc_next;

  // Next-state and next-PC selection; halt beats predict, redirect/pending beat halt.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pc_next      = pc_reg;
    pend_next    = pend_reg;
    pend_pc_next = pend_pc_reg;
    case (state_reg)
      ST_BOOT: begin
        if (i_redirect) begin
          pend_next    = 1'b1;
          pend_pc_next = i_redirect_pc;
        end
        if (cnt_reg == BOOT_LAST) begin
          state_next = ST_RUN;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_RUN: begin
        if (i_pc_enable) begin
          if (i_redirect) begin
            pc_next   = i_redirect_pc & align_mask;
            pend_next = 1'b0;
          end else if (pend_reg) begin
            pc_next   = pend_pc_reg & align_mask;
            pend_next = 1'b0;
          end else if (i_halt) begin
            state_next = ST_HALT;
          end else if (i_predict_taken) begin
            pc_next = i_predict_pc & align_mask;
          end else begin
            pc_next = pc_reg + XLEN'(4);
          end
        end else if (i_redirect) begin
          // Stalled: remember only the most recent correction.
          pend_next    = 1'b1;
          pend_pc_next = i_redirect_pc;
        end
      end
      ST_HALT: begin
        if (i_redirect) begin
          pc_next    = i_redirect_pc & align_mask;
          pend_next  = 1'b0;
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_BOOT;
        cnt_next   = 4'd0;
      end
    endcase
    valid_next = (state_next == ST_RUN);
  end

  // State register with synchronous active-low reset; pending target is discarded on reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= ST_BOOT;
      cnt_reg     <= 4'd0;
      pc_reg      <= RESET_VEC;
      valid_reg   <= 1'b0;
      pend_reg    <= 1'b0;
      pend_pc_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pc_reg      <= pc_next;
      valid_reg   <= valid_next;
      pend_reg    <= pend_next;
      pend_pc_reg <= pend_pc_next;
    end
  end

  assign o_pc               = pc_reg;
  assign o_pc_plus4         = pc_reg + XLEN'(4);
  assign o_valid            = valid_reg;
  assign o_redirect_pending = pend_reg;

endmodule
